// File: rtl/kmeans_pkg.sv
// Shared sizing, FSM encoding and center-record layout for the k-means
// nearest-center scheduler.
package kmeans_pkg;
    localparam int K            = 8;
    localparam int KW           = $clog2(K);
    localparam int DIM_SIZE     = 8;
    localparam int COUNTER_SIZE = 7;
    localparam int ACC_SIZE     = 10;
    localparam int DIST_W       = 40;

    // Center record is {accX, accY, accZ, n} with n in the LSBs.
    localparam int RD_W     = 3*ACC_SIZE + COUNTER_SIZE;
    localparam int N_LSB    = 0;
    localparam int ACCZ_LSB = COUNTER_SIZE;
    localparam int ACCY_LSB = COUNTER_SIZE + ACC_SIZE;
    localparam int ACCX_LSB = COUNTER_SIZE + 2*ACC_SIZE;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LAT  = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic [KW:0] clamp_count(input logic [KW:0] n);
        return (n > (KW+1)'(K)) ? (KW+1)'(K) : n;
    endfunction
endpackage

// File: rtl/nearest_center_sched_if.sv
// Bundle of the scan request/result, center-store read and distance-unit
// signals around the nearest-center scheduler.
interface nearest_center_sched_if;
    import kmeans_pkg::*;

    logic                    start;
    logic [DIM_SIZE-1:0]     point_x, point_y, point_z;
    logic [KW:0]             num_centers;
    logic                    c_rd_en;
    logic [KW-1:0]           c_rd_addr;
    logic [RD_W-1:0]         c_rd_data;
    logic [DIM_SIZE-1:0]     d_point_x, d_point_y, d_point_z;
    logic [ACC_SIZE-1:0]     d_accX, d_accY, d_accZ;
    logic [COUNTER_SIZE-1:0] d_counter;
    logic [DIST_W-1:0]       d_dist;
    logic                    busy;
    logic                    done;
    logic                    best_valid;
    logic [KW-1:0]           best_idx;
    logic [DIST_W-1:0]       best_dist;
    logic [COUNTER_SIZE-1:0] best_n;

    modport master (
        input  start, point_x, point_y, point_z, num_centers, c_rd_data, d_dist,
        output c_rd_en, c_rd_addr, d_point_x, d_point_y, d_point_z,
               d_accX, d_accY, d_accZ, d_counter,
               busy, done, best_valid, best_idx, best_dist, best_n
    );

    modport slave (
        output start, point_x, point_y, point_z, num_centers, c_rd_data, d_dist,
        input  c_rd_en, c_rd_addr, d_point_x, d_point_y, d_point_z,
               d_accX, d_accY, d_accZ, d_counter,
               busy, done, best_valid, best_idx, best_dist, best_n
    );
endinterface

// File: rtl/frac_less.sv
// Compares d_a/n_a^2 < d_b/n_b^2 without division by cross-multiplying.
module frac_less
    import kmeans_pkg::*;
(
    input  logic [DIST_W-1:0]       d_a,
    input  logic [COUNTER_SIZE-1:0] n_a,
    input  logic [DIST_W-1:0]       d_b,
    input  logic [COUNTER_SIZE-1:0] n_b,
    output logic                    lt
);
    localparam int PW = DIST_W + 2*COUNTER_SIZE;

    logic [PW-1:0] lhs;
    logic [PW-1:0] rhs;

    assign lhs = PW'(d_a) * PW'(n_b) * PW'(n_b);
    assign rhs = PW'(d_b) * PW'(n_a) * PW'(n_a);
    assign lt  = lhs < rhs;
endmodule

// File: rtl/nearest_center_sched.sv
// Scans up to K centers for one point, feeding the distance unit and keeping
// the nearest non-empty center by scaled-distance comparison.
module nearest_center_sched
    import kmeans_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    nearest_center_sched_if.master        bus
);
    state_t                  state_reg;
    logic [KW:0]             count_reg;
    logic [KW:0]             idx_reg;
    logic [KW:0]             idx_next;
    logic [DIM_SIZE-1:0]     px_reg, py_reg, pz_reg;
    logic                    c_rd_en_reg;
    logic [KW-1:0]           c_rd_addr_reg;
    logic [DIM_SIZE-1:0]     d_px_reg, d_py_reg, d_pz_reg;
    logic [ACC_SIZE-1:0]     d_ax_reg, d_ay_reg, d_az_reg;
    logic [COUNTER_SIZE-1:0] d_n_reg;
    logic                    busy_reg, done_reg;
    logic                    best_valid_reg;
    logic [KW-1:0]           best_idx_reg;
    logic [DIST_W-1:0]       best_dist_reg;
    logic [COUNTER_SIZE-1:0] best_n_reg;
    logic [KW:0]             start_count;
    logic                    cand_lt;

    assign idx_next    = idx_reg + 1'b1;
    assign start_count = clamp_count(bus.num_centers);

    frac_less u_frac_less (
        .d_a (bus.d_dist),
        .n_a (d_n_reg),
        .d_b (best_dist_reg),
        .n_b (best_n_reg),
        .lt  (cand_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            idx_reg        <= '0;
            px_reg         <= '0;
            py_reg         <= '0;
            pz_reg         <= '0;
            c_rd_en_reg    <= 1'b0;
            c_rd_addr_reg  <= '0;
            d_px_reg       <= '0;
            d_py_reg       <= '0;
            d_pz_reg       <= '0;
            d_ax_reg       <= '0;
            d_ay_reg       <= '0;
            d_az_reg       <= '0;
            d_n_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            best_valid_reg <= 1'b0;
            best_idx_reg   <= '0;
            best_dist_reg  <= '1;
            best_n_reg     <= '0;
        end else begin
            c_rd_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        px_reg         <= bus.point_x;
                        py_reg         <= bus.point_y;
                        pz_reg         <= bus.point_z;
                        count_reg      <= start_count;
                        idx_reg        <= '0;
                        best_valid_reg <= 1'b0;
                        best_idx_reg   <= '0;
                        best_dist_reg  <= '1;
                        best_n_reg     <= '0;
                        busy_reg       <= 1'b1;
                        if (start_count == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= RD;
                            c_rd_en_reg   <= 1'b1;
                            c_rd_addr_reg <= '0;
                        end
                    end
                end
                RD: state_reg <= LAT;
                LAT: begin
                    d_px_reg  <= px_reg;
                    d_py_reg  <= py_reg;
                    d_pz_reg  <= pz_reg;
                    d_ax_reg  <= bus.c_rd_data[ACCX_LSB +: ACC_SIZE];
                    d_ay_reg  <= bus.c_rd_data[ACCY_LSB +: ACC_SIZE];
                    d_az_reg  <= bus.c_rd_data[ACCZ_LSB +: ACC_SIZE];
                    d_n_reg   <= bus.c_rd_data[N_LSB +: COUNTER_SIZE];
                    state_reg <= CMP;
                end
                CMP: begin
                    // Empty centers never win; the first non-empty one always does.
                    if (d_n_reg != '0 && (!best_valid_reg || cand_lt)) begin
                        best_valid_reg <= 1'b1;
                        best_idx_reg   <= idx_reg[KW-1:0];
                        best_dist_reg  <= bus.d_dist;
                        best_n_reg     <= d_n_reg;
                    end
                    idx_reg <= idx_next;
                    if (idx_next < count_reg) begin
                        state_reg     <= RD;
                        c_rd_en_reg   <= 1'b1;
                        c_rd_addr_reg <= idx_next[KW-1:0];
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.c_rd_en    = c_rd_en_reg;
    assign bus.c_rd_addr  = c_rd_addr_reg;
    assign bus.d_point_x  = d_px_reg;
    assign bus.d_point_y  = d_py_reg;
    assign bus.d_point_z  = d_pz_reg;
    assign bus.d_accX     = d_ax_reg;
    assign bus.d_accY     = d_ay_reg;
    assign bus.d_accZ     = d_az_reg;
    assign bus.d_counter  = d_n_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.best_valid = best_valid_reg;
    assign bus.best_idx   = best_idx_reg;
    assign bus.best_dist  = best_dist_reg;
    assign bus.best_n     = best_n_reg;
endmodule

// File: tb/tb_nearest_center_sched.sv
// Directed table-driven bench for nearest_center_sched with a center-store
// model and a functional distance-unit model.
module tb_nearest_center_sched;
    import kmeans_pkg::*;

    localparam int NV = 6;
    localparam logic [DIST_W-1:0] ONES = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nearest_center_sched_if bus ();

    nearest_center_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [KW:0]             num;
        logic [DIM_SIZE-1:0]     px, py, pz;
        logic                    ev;
        logic [KW-1:0]           eidx;
        logic [DIST_W-1:0]       edist;
        logic [COUNTER_SIZE-1:0] en;
        int                      elat;
        int                      ereads;
    } vec_t;

    vec_t            vecs [NV];
    logic [RD_W-1:0] cmem [NV][K];
    logic [RD_W-1:0] mem  [K];
    int              rd_q [$];
    int              checks = 0;
    int              failures = 0;

    // Center store: registered read, data valid the cycle after c_rd_en.
    always @(posedge clk) begin
        if (bus.c_rd_en) begin
            bus.c_rd_data <= mem[bus.c_rd_addr];
            rd_q.push_back(int'(bus.c_rd_addr));
        end
    end

    // Distance unit: n^2 * |p - s/n|^2 == |n*p - s|^2.
    always_comb begin
        longint dx, dy, dz;
        dx = longint'(bus.d_counter) * longint'(bus.d_point_x) - longint'(bus.d_accX);
        dy = longint'(bus.d_counter) * longint'(bus.d_point_y) - longint'(bus.d_accY);
        dz = longint'(bus.d_counter) * longint'(bus.d_point_z) - longint'(bus.d_accZ);
        bus.d_dist = DIST_W'(dx*dx + dy*dy + dz*dz);
    end

    function automatic logic [RD_W-1:0] pack_c(input int n, input int x, input int y, input int z);
        return {ACC_SIZE'(x), ACC_SIZE'(y), ACC_SIZE'(z), COUNTER_SIZE'(n)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int vi, input int glitch_at, input bit start_on_done);
        int lat;
        bit got;
        bit seq_ok;
        for (int c = 0; c < K; c++) mem[c] = cmem[vi][c];
        rd_q.delete();
        @(negedge clk);
        bus.num_centers = vecs[vi].num;
        bus.point_x     = vecs[vi].px;
        bus.point_y     = vecs[vi].py;
        bus.point_z     = vecs[vi].pz;
        bus.start       = 1'b1;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (c > 1) @(posedge clk);
            #1;
            bus.start   = (c == glitch_at);
            bus.point_x = 8'd0;
            bus.point_y = 8'd0;
            bus.point_z = 8'd0;
            if (bus.done) begin
                lat = c;
                got = 1'b1;
            end
        end
        bus.start = start_on_done;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("latency", 64'(lat), 64'(vecs[vi].elat));
        chk("done_one_cycle", {62'd0, bus.done, bus.busy}, 64'd0);
        chk("best_valid", 64'(bus.best_valid), 64'(vecs[vi].ev));
        chk("best_idx", 64'(bus.best_idx), 64'(vecs[vi].eidx));
        chk("best_dist", 64'(bus.best_dist), 64'(vecs[vi].edist));
        chk("best_n", 64'(bus.best_n), 64'(vecs[vi].en));
        chk("read_count", 64'(rd_q.size()), 64'(vecs[vi].ereads));
        seq_ok = (rd_q.size() == vecs[vi].ereads);
        foreach (rd_q[j]) if (rd_q[j] != j) seq_ok = 1'b0;
        chk("addr_seq", 64'(seq_ok), 64'd1);
        $display("vec %0d: lat=%0d valid=%0d idx=%0d dist=%0h n=%0d reads=%0d",
                 vi, lat, bus.best_valid, bus.best_idx, bus.best_dist, bus.best_n, rd_q.size());
    endtask

    initial begin
        int seen_done;
        bus.start       = 1'b0;
        bus.num_centers = '0;
        bus.point_x     = '0;
        bus.point_y     = '0;
        bus.point_z     = '0;
        for (int v = 0; v < NV; v++)
            for (int c = 0; c < K; c++) cmem[v][c] = '0;

        // 0: basic, tie on center 3 keeps center 1
        vecs[0] = '{num:4, px:10, py:10, pz:10, ev:1, eidx:1, edist:3, en:1, elat:13, ereads:4};
        cmem[0][0] = pack_c(1, 0, 0, 0);
        cmem[0][1] = pack_c(1, 9, 9, 9);
        cmem[0][2] = pack_c(1, 50, 50, 50);
        cmem[0][3] = pack_c(1, 11, 11, 11);
        // 1: mixed counts, 16/1 vs 16/16
        vecs[1] = '{num:2, px:4, py:0, pz:0, ev:1, eidx:1, edist:16, en:4, elat:7, ereads:2};
        cmem[1][0] = pack_c(1, 0, 0, 0);
        cmem[1][1] = pack_c(4, 12, 0, 0);
        // 2: zero centers
        vecs[2] = '{num:0, px:1, py:2, pz:3, ev:0, eidx:0, edist:ONES, en:0, elat:1, ereads:0};
        // 3: all empty
        vecs[3] = '{num:3, px:5, py:5, pz:5, ev:0, eidx:0, edist:ONES, en:0, elat:10, ereads:3};
        cmem[3][1] = pack_c(0, 7, 7, 7);
        // 4: clamp 12 -> 8, center 4 exact hit
        vecs[4] = '{num:12, px:20, py:20, pz:20, ev:1, eidx:4, edist:0, en:1, elat:25, ereads:8};
        for (int c = 0; c < K; c++) cmem[4][c] = pack_c(1, 5*c, 5*c, 5*c);
        // 5: leading empty skipped, scaled tie 4/4 vs 1/1 keeps center 1
        vecs[5] = '{num:3, px:5, py:5, pz:5, ev:1, eidx:1, edist:4, en:2, elat:10, ereads:3};
        cmem[5][0] = pack_c(0, 0, 0, 0);
        cmem[5][1] = pack_c(2, 8, 10, 10);
        cmem[5][2] = pack_c(1, 5, 5, 6);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_c_rd_en", 64'(bus.c_rd_en), 64'd0);
        chk("rst_best_valid", 64'(bus.best_valid), 64'd0);
        chk("rst_best_idx", 64'(bus.best_idx), 64'd0);
        chk("rst_best_n", 64'(bus.best_n), 64'd0);
        chk("rst_best_dist", 64'(bus.best_dist), 64'(ONES));

        for (int v = 0; v < NV; v++) run_vec(v, 0, 1'b0);

        // start mid-scan and start during done are ignored; then back-to-back
        run_vec(0, 5, 1'b1);
        run_vec(1, 0, 1'b0);

        // reset at t0+5 aborts without done
        for (int c = 0; c < K; c++) mem[c] = cmem[4][c];
        @(negedge clk);
        bus.num_centers = 4'd8;
        bus.point_x = 8'd20; bus.point_y = 8'd20; bus.point_z = 8'd20;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen_done = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_best_dist", 64'(bus.best_dist), 64'(ONES));
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        $display("reset mid-scan: done pulses seen=%0d", seen_done);

        run_vec(0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
